// File: rtl/int_sched.sv
// int_sched: two-channel gate-pulse scheduler with round-robin grants, holdoff and overcurrent skip.
// Optional macro DUTY_LIMIT_EN stretches holdoff to at least the preceding pulse width.
module int_sched #(
    parameter int CLK_MHZ      = 100,
    parameter int HOLDOFF_US   = 20,
    parameter int SKIP_CNT_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] pw_a,
    input  logic [7:0] pw_b,
    input  logic       ocd,
    output logic       int_out,
    output logic       grant_a,
    output logic       grant_b,
    output logic       active_ch,
    output logic       fault
);
    localparam int CNT_W  = $clog2(255 * CLK_MHZ + 1);
    localparam int SKIP_W = (SKIP_CNT_MAX < 1) ? 1 : $clog2(SKIP_CNT_MAX + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ON      = 2'd1;
    localparam logic [1:0] S_HOLDOFF = 2'd2;
    localparam logic [1:0] S_FAULT   = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CLK_C       = CNT_W'(CLK_MHZ);
    localparam logic [CNT_W-1:0]  HOLD_CYC    = CNT_W'(HOLDOFF_US * CLK_MHZ);
    localparam logic [SKIP_W-1:0] SKIP_ZERO   = {SKIP_W{1'b0}};
    localparam logic [SKIP_W-1:0] SKIP_ONE    = SKIP_W'(1);
    localparam logic [SKIP_W-1:0] SKIP_RELOAD = SKIP_W'(SKIP_CNT_MAX);
`ifdef DUTY_LIMIT_EN
    localparam logic [7:0]        HOLD_US8    = 8'(HOLDOFF_US);
`endif

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic              req_a_q, req_a_d, req_b_q, req_b_d;
    logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic              grant_a_q, grant_a_d, grant_b_q, grant_b_d;
    logic              on_q, on_d;
    logic              active_ch_q, active_ch_d;
    logic              fault_q, fault_d;
`ifdef DUTY_LIMIT_EN
    logic [7:0]        pw_q, pw_d;
`endif

    logic              rise_a, rise_b, pick_a, pick_b;
    logic [7:0]        sel_pw;
    logic [CNT_W-1:0]  hold_len;

    // Request edges and round-robin choice; active_ch_q doubles as the last-granted channel.
    always_comb begin
        rise_a = req_a & ~req_a_q;
        rise_b = req_b & ~req_b_q;
        pick_a = pend_a_q & (~pend_b_q | active_ch_q);
        pick_b = pend_b_q & ~pick_a;
        sel_pw = pick_a ? pw_a : pw_b;
    end

    // Holdoff length, optionally stretched to the preceding pulse width.
    always_comb begin
`ifdef DUTY_LIMIT_EN
        if (pw_q > HOLD_US8) begin
            hold_len = CNT_W'(pw_q) * CLK_C;
        end else begin
            hold_len = HOLD_CYC;
        end
`else
        hold_len = HOLD_CYC;
`endif
    end

    // Next-state logic; ocd overrides every state and aborts any grant.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        skip_cnt_d  = skip_cnt_q;
        on_d        = on_q;
        active_ch_d = active_ch_q;
        grant_a_d   = 1'b0;
        grant_b_d   = 1'b0;
        req_a_d     = req_a;
        req_b_d     = req_b;
`ifdef DUTY_LIMIT_EN
        pw_d        = pw_q;
`endif
        if (ocd) begin
            state_d    = S_FAULT;
            skip_cnt_d = SKIP_RELOAD;
            on_d       = 1'b0;
            cnt_d      = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_a | pick_b) begin
                        grant_a_d   = pick_a;
                        grant_b_d   = pick_b;
                        active_ch_d = pick_b;
                        if (sel_pw != 8'd0) begin
                            state_d = S_ON;
                            on_d    = 1'b1;
                            cnt_d   = (CNT_W'(sel_pw) * CLK_C) - CNT_ONE;
`ifdef DUTY_LIMIT_EN
                            pw_d    = sel_pw;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ON: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = S_HOLDOFF;
                        on_d    = 1'b0;
                        cnt_d   = hold_len - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_FAULT: begin
                    // Grants here only burn requests until the skip budget is spent.
                    if (skip_cnt_q == SKIP_ZERO) begin
                        state_d = S_HOLDOFF;
                        cnt_d   = hold_len - CNT_ONE;
                    end else if (pick_a | pick_b) begin
                        grant_a_d   = pick_a;
                        grant_b_d   = pick_b;
                        active_ch_d = pick_b;
                        skip_cnt_d  = skip_cnt_q - SKIP_ONE;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    on_d    = 1'b0;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
        pend_a_d = rise_a | (pend_a_q & ~grant_a_d);
        pend_b_d = rise_b | (pend_b_q & ~grant_b_d);
        fault_d  = (state_d == S_FAULT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            skip_cnt_q  <= SKIP_RELOAD;
            req_a_q     <= 1'b0;
            req_b_q     <= 1'b0;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            grant_a_q   <= 1'b0;
            grant_b_q   <= 1'b0;
            on_q        <= 1'b0;
            active_ch_q <= 1'b1;
            fault_q     <= 1'b0;
`ifdef DUTY_LIMIT_EN
            pw_q        <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            skip_cnt_q  <= skip_cnt_d;
            req_a_q     <= req_a_d;
            req_b_q     <= req_b_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            grant_a_q   <= grant_a_d;
            grant_b_q   <= grant_b_d;
            on_q        <= on_d;
            active_ch_q <= active_ch_d;
            fault_q     <= fault_d;
`ifdef DUTY_LIMIT_EN
            pw_q        <= pw_d;
`endif
        end
    end

    assign int_out   = on_q & ~ocd;
    assign grant_a   = grant_a_q;
    assign grant_b   = grant_b_q;
    assign active_ch = active_ch_q;
    assign fault     = fault_q;

endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 The block SHALL have parameter CLK_MHZ, default 100, meaning clock cycles per microsecond.
REQ-002 The block SHALL have parameter HOLDOFF_US, default 20, meaning the minimum gate-off time between pulses in microseconds (1..255).
REQ-003 The block SHALL have parameter SKIP_CNT_MAX, default 3, meaning the number of granted requests dropped after an overcurrent event.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Ports req_a and req_b, input, 1 bit each: pulse requests from channels A and B, synchronous to clk; the rising edge is the request.
REQ-007 Ports pw_a and pw_b, input, 8 bits each: requested on-time in microseconds, sampled at grant.
REQ-008 Port ocd, input, 1 bit: overcurrent detect, synchronous to clk, active-high.
REQ-009 Port int_out, output, 1 bit: gate enable to the bridge driver.
REQ-010 Ports grant_a and grant_b, output, 1 bit each: single-cycle grant strobes.
REQ-011 Port active_ch, output, 1 bit: channel owning the current or last pulse (0=A, 1=B).
REQ-012 Port fault, output, 1 bit: high while in FAULT.

Function
REQ-013 Each channel SHALL have a pending flag, set at the clock edge sampling req_x=1 with the previous sample 0, and cleared at the edge asserting grant_x; a new edge while pending is already set SHALL be coalesced.
REQ-014 The FSM SHALL have states IDLE, ON, HOLDOFF and FAULT.
REQ-015 In IDLE with any pending flag set, the block SHALL grant one channel, latch its pw, and pulse grant_x for one cycle.
REQ-016 When both channels are pending, the grant SHALL go to the channel not granted last (round-robin); after reset, A wins first.
REQ-017 On a grant with pw≠0, the FSM SHALL enter ON, with int_out high for exactly pw*CLK_MHZ cycles, then enter HOLDOFF.
REQ-018 On a grant with pw=0, the request SHALL be consumed, int_out SHALL stay low, and the FSM SHALL remain in IDLE.
REQ-019 Latency: a req rising edge sampled at edge k with the FSM in IDLE SHALL give a grant at edge k+1 and int_out high from edge k+1.
REQ-020 HOLDOFF SHALL last HOLDOFF_US*CLK_MHZ cycles, then the FSM SHALL return to IDLE; requests arriving during ON or HOLDOFF SHALL remain pending.
REQ-021 int_out SHALL equal on_reg AND NOT ocd (combinational kill); ocd=1 in any state SHALL move the FSM to FAULT at the next edge and reload skip_cnt=SKIP_CNT_MAX.
REQ-022 In FAULT, each grant SHALL consume the request and decrement skip_cnt with no pulse; at skip_cnt=0 with ocd=0, the FSM SHALL enter HOLDOFF.
REQ-023 Counter widths SHALL hold 255*CLK_MHZ without overflow; counters SHALL NOT wrap.
REQ-024 If req and grant for the same channel occur on the same edge, the pending flag SHALL end set only if the req edge is new.

Reset
REQ-025 Under rst=1, the block SHALL force state=IDLE, all pending flags 0, int_out=0, grant_a=grant_b=0, active_ch=1, fault=0, skip_cnt=SKIP_CNT_MAX, all counters 0.
REQ-026 Reset asserted mid-pulse SHALL drop int_out immediately, asynchronously, and discard all pending requests.

Configuration
REQ-027 With DUTY_LIMIT_EN defined, the HOLDOFF length SHALL be max(HOLDOFF_US, pw of the preceding pulse)*CLK_MHZ cycles, limiting duty to ≤50%.
REQ-028 Without DUTY_LIMIT_EN, the HOLDOFF length SHALL be fixed at HOLDOFF_US*CLK_MHZ cycles.

Verification
REQ-029 req_a edge with pw_a=50 -> grant_a 1 cycle, int_out high exactly 5000 cycles, then low ≥2000 cycles.
REQ-030 req_a and req_b on the same edge -> A pulse, holdoff, then B pulse; repeating both -> alternating A, B.
REQ-031 ocd=1 at cycle 1000 of a 10000-cycle pulse -> int_out low the same cycle, fault=1, next 3 grants produce no pulse, 4th grant pulses.
REQ-032 pw_b=0 request -> grant_b strobe, int_out stays 0, no holdoff, and an immediate following req_a is serviced.
REQ-033 With DUTY_LIMIT_EN, pw_a=200 -> holdoff 20000 cycles; without the macro -> 2000 cycles.
REQ-034 rst asserted during ON with both channels pending -> int_out 0 immediately; after release, no pulse without a new req edge.
